load_store_seq: RTL and testbench
=================================

LOAD_STORE_SEQ -- requirements
Module: load_store_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the data memory byte-address width.
REQ-002 SHALL have ports: clk  input  1  rising-edge clock; rst_n  input  1  synchronous active-low reset.
REQ-003 SHALL have ports: req_valid  input  1  core access request; req_ready  output  1  request accepted this cycle.
REQ-004 SHALL have ports: req_write  input  1  1=store 0=load; req_half  input  1  1=16-bit 0=8-bit; req_signed  input  1  sign-extend byte load.
REQ-005 SHALL have ports: req_addr  input  16  byte address; req_wdata  input  16  store data.
REQ-006 SHALL have ports: resp_valid  output  1  one-cycle completion pulse; resp_rdata  output  16  load result; resp_err  output  1  access rejected.
REQ-007 SHALL have ports: mem_we  output  1  byte write strobe; mem_addr  output  ADDR_W  byte address; mem_wdata  output  8  write byte; mem_rdata  input  8  asynchronous read byte from data memory.

Function
REQ-008 SHALL implement FSM IDLE, ACC0, ACC1, DONE; req_ready=1 only in IDLE.
REQ-009 SHALL, in IDLE with req_valid=1, register the request and go to ACC0; with req_valid=0, stay in IDLE.
REQ-010 SHALL, in ACC0, drive mem_addr=req_addr[ADDR_W-1:0] and mem_wdata=wdata[7:0], capture mem_rdata as the low byte, then go to ACC1 if half, else to DONE.
REQ-011 SHALL, in ACC1, drive mem_addr=(addr+1) mod 2^ADDR_W and mem_wdata=wdata[15:8], capture mem_rdata as the high byte, then go to DONE.
REQ-012 SHALL assert mem_we only in ACC0/ACC1 for stores; mem_we=0 in all other states and for loads.
REQ-013 SHALL assert resp_valid for exactly the DONE cycle, then return to IDLE; DONE lasts one cycle with no backpressure.
REQ-014 SHALL give latency from the acceptance cycle N: byte access resp_valid at N+2; halfword access at N+3.
REQ-015 SHALL form resp_rdata as: halfword {hi,lo}; byte load zero-extended, or sign-extended from bit 7 if req_signed; stores return 0x0000.
REQ-016 SHALL use little-endian byte order and ignore req_addr bits above ADDR_W-1.
REQ-017 SHALL hold resp_rdata and resp_err stable outside DONE at their last values; mem_addr and mem_wdata SHALL be 0 in IDLE and DONE.

Reset
REQ-018 SHALL, on rst_n=0 at a clk edge, set state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, and clear all captured request registers.
REQ-019 SHALL abandon any in-flight access on reset without a response; a half-completed halfword store SHALL leave only its low byte written.

Configuration
REQ-020 SHALL provide macro LSU_MISALIGN_TRAP_EN: when defined, an accepted halfword with addr[0]=1 SHALL go IDLE->DONE directly with resp_err=1, resp_rdata=0 and no mem_we.
REQ-021 SHALL, without LSU_MISALIGN_TRAP_EN, perform misaligned halfwords normally per REQ-010/011 and hold resp_err=0 permanently.

Structure
REQ-022 SHALL place the FSM state enum and the halfword/byte size constants in shared package lsu_pkg.
REQ-023 SHALL implement the byte/half zero/sign extension in combinational sub-module load_ext.

Verification
REQ-024 SHALL cover: store half 0xBEEF @0x010 -> mem_we at N+1 (addr 0x010, data 0xEF) and N+2 (addr 0x011, data 0xBE), resp_valid at N+3.
REQ-025 SHALL cover: byte 0x80 @0x020, signed load -> resp_rdata=0xFF80 at N+2; unsigned load -> 0x0080.
REQ-026 SHALL cover: half load @0x7FF (ADDR_W=11), mem[0x7FF]=0x34, mem[0x000]=0x12 -> resp_rdata=0x1234 at N+3 without macro; with macro -> resp_err=1 at N+1, mem_we never asserted.
REQ-027 SHALL cover: req_valid held high during ACC0/ACC1/DONE -> req_ready=0 and no second acceptance until IDLE.
REQ-028 SHALL cover: rst_n=0 during ACC1 of a half store 0xA55A @0x040 -> mem[0x040]=0x5A, mem[0x041] unchanged, no resp_valid, req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and size constants for the byte-serial load/store sequencer.
package lsu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load result formatting: halfword merge, byte zero/sign extension.
module load_ext
  import lsu_pkg::*;
(
  input  logic              half_i,
  input  logic              signed_i,
  input  logic [BYTE_W-1:0] lo_i,
  input  logic [BYTE_W-1:0] hi_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = {BYTE_W'(0), lo_i};
    if (half_i == SIZE_HALF) begin
      data_o = {hi_i, lo_i};
    end else if (signed_i) begin
      data_o = {{BYTE_W{lo_i[BYTE_W-1]}}, lo_i};
    end
  end

endmodule

// File: rtl/load_store_seq.sv
// Sequences 8/16-bit core loads/stores onto an 8-bit little-endian data memory.
// Optional LSU_MISALIGN_TRAP_EN rejects odd-address halfwords with resp_err.
module load_store_seq
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_half,
  input  logic              req_signed,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              resp_valid,
  output logic [15:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic              half_q, half_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [7:0]        lo_q, lo_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [15:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              trap_c;
  logic [7:0]        ext_lo_c;
  logic [15:0]       ext_data_c;
  logic              unused_addr_c;

  assign unused_addr_c = ^req_addr[15:ADDR_W];

  // In ACC0 the low byte is still on the memory read port, not yet in lo_q.
  assign ext_lo_c = (state_q == ACC0) ? mem_rdata : lo_q;

  load_ext u_load_ext (
    .half_i   (half_q),
    .signed_i (signed_q),
    .lo_i     (ext_lo_c),
    .hi_i     (mem_rdata),
    .data_o   (ext_data_c)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    half_d       = half_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    trap_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          half_d   = req_half;
          signed_d = req_signed;
          addr_d   = req_addr[ADDR_W-1:0];
          wdata_d  = req_wdata;
          state_d  = ACC0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_half == SIZE_HALF && req_addr[0]) begin
            trap_c  = 1'b1;
            state_d = DONE;
          end
`endif
        end
      end
      ACC0: begin
        lo_d    = mem_rdata;
        state_d = (half_q == SIZE_HALF) ? ACC1 : DONE;
      end
      ACC1:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Memory-side outputs are registered from the state being entered.
    case (state_d)
      ACC0: begin
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d[7:0];
      end
      ACC1: begin
        mem_addr_d  = addr_d + ADDR_W'(1);
        mem_wdata_d = wdata_d[15:8];
      end
      default: ;
    endcase

    mem_we_d     = write_d && (state_d == ACC0 || state_d == ACC1);
    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);

    if (trap_c) begin
      resp_rdata_d = '0;
      resp_err_d   = 1'b1;
    end else if (state_d == DONE) begin
      resp_rdata_d = write_q ? 16'h0000 : ext_data_c;
      resp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      half_q       <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lo_q         <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      half_q       <= half_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Reset must suppress a strobe already launched for the edge it lands on.
  assign mem_we     = mem_we_q && rst_n;
  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_seq.sv
// Directed, table-driven bench for load_store_seq with an 8-bit byte memory model.
module tb_load_store_seq;

  localparam int unsigned ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write, req_half, req_signed;
  logic [15:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [15:0]       resp_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [7:0]        pre_data;

  int n_vec  = 0;
  int n_miss = 0;

  logic              we_tr   [0:7];
  logic [ADDR_W-1:0] addr_tr [0:7];
  logic [7:0]        wd_tr   [0:7];
  logic              rdy_tr  [0:7];

  always #5 clk = ~clk;

  load_store_seq #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_half   (req_half),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic        w, h, s;
    logic [15:0] addr, wdata;
    logic [7:0]  pre_lo, pre_hi;
    logic [15:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [7:0]  exp_lo, exp_hi;
  } vec_t;

  vec_t vecs [0:9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issues one request and traces the DUT until resp_valid or a cycle budget expires.
  task automatic run_req(input logic w, input logic h, input logic s,
                         input logic [15:0] a, input logic [15:0] wd, input bit hold,
                         output logic [15:0] rd, output logic er,
                         output int lat, output int wes);
    rd = '0; er = 1'b0; lat = -1; wes = 0;
    for (int k = 0; k < 8; k++) begin
      we_tr[k] = 1'b0; addr_tr[k] = '0; wd_tr[k] = '0; rdy_tr[k] = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_half = h; req_signed = s;
    req_addr = a; req_wdata = wd;
    rdy_tr[0] = req_ready;
    @(posedge clk);
    #1 if (!hold) req_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      we_tr[k] = mem_we; addr_tr[k] = mem_addr; wd_tr[k] = mem_wdata; rdy_tr[k] = req_ready;
      if (mem_we) wes++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  logic [15:0]       rd;
  logic              er;
  int                lat, wes;
  logic [ADDR_W-1:0] a0, a1;
  logic              seen;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 8'h80, 8'h00, 16'h0080, 1'b0, 2, 0, 8'h80, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0020, 16'h0000, 8'h80, 8'h00, 16'hFF80, 1'b0, 2, 0, 8'h80, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0030, 16'h0000, 8'h7F, 8'h11, 16'h007F, 1'b0, 2, 0, 8'h7F, 8'h11};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 8'hCD, 8'hAB, 16'hABCD, 1'b0, 3, 0, 8'hCD, 8'hAB};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h07FF, 16'h0000, 8'h34, 8'h12, 16'h0000, 1'b1, 1, 0, 8'h34, 8'h12};
`else
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h07FF, 16'h0000, 8'h34, 8'h12, 16'h1234, 1'b0, 3, 0, 8'h34, 8'h12};
`endif
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0200, 16'h5566, 8'h00, 8'hAA, 16'h0000, 1'b0, 2, 1, 8'h66, 8'hAA};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 8'h00, 8'h00, 16'h0000, 1'b0, 3, 2, 8'hEF, 8'hBE};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 16'hF845, 16'h0000, 8'h9C, 8'h00, 16'h009C, 1'b0, 2, 0, 8'h9C, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 16'h0300, 16'h0000, 8'h01, 8'h80, 16'h8001, 1'b0, 3, 0, 8'h01, 8'h80};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h0051, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b1, 1, 0, 8'h00, 8'h00};
`else
    vecs[9] = '{1'b1, 1'b1, 1'b0, 16'h0051, 16'h1234, 8'h00, 8'h00, 16'h0000, 1'b0, 3, 2, 8'h34, 8'h12};
`endif

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", 32'(resp_rdata), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a0 = vecs[i].addr[ADDR_W-1:0];
      a1 = a0 + ADDR_W'(1);
      preload(a0, vecs[i].pre_lo);
      preload(a1, vecs[i].pre_hi);
      run_req(vecs[i].w, vecs[i].h, vecs[i].s, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, lat, wes);
      chk($sformatf("v%0d ready", i), 32'(rdy_tr[0]), 32'd1);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d we count", i), 32'(wes), 32'(vecs[i].exp_wes));
      @(negedge clk);
      chk($sformatf("v%0d rdata held", i), 32'(resp_rdata), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d pulse end", i), 32'(resp_valid), 32'd0);
      chk($sformatf("v%0d idle addr", i), 32'(mem_addr), 32'd0);
      chk($sformatf("v%0d mem lo", i), 32'(mem[a0]), 32'(vecs[i].exp_lo));
      chk($sformatf("v%0d mem hi", i), 32'(mem[a1]), 32'(vecs[i].exp_hi));
    end

    // Halfword store byte-lane timing.
    preload(11'h010, 8'h00);
    preload(11'h011, 8'h00);
    run_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b0, rd, er, lat, wes);
    chk("st16 we N+1", 32'(we_tr[1]), 32'd1);
    chk("st16 addr N+1", 32'(addr_tr[1]), 32'h010);
    chk("st16 data N+1", 32'(wd_tr[1]), 32'hEF);
    chk("st16 we N+2", 32'(we_tr[2]), 32'd1);
    chk("st16 addr N+2", 32'(addr_tr[2]), 32'h011);
    chk("st16 data N+2", 32'(wd_tr[2]), 32'hBE);
    chk("st16 we DONE", 32'(we_tr[3]), 32'd0);
    chk("st16 addr DONE", 32'(addr_tr[3]), 32'd0);
    chk("st16 latency", 32'(lat), 32'd3);

    // req_valid held high through the whole access.
    run_req(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, rd, er, lat, wes);
    chk("hold ready ACC0", 32'(rdy_tr[1]), 32'd0);
    chk("hold ready ACC1", 32'(rdy_tr[2]), 32'd0);
    chk("hold ready DONE", 32'(rdy_tr[3]), 32'd0);
    chk("hold latency", 32'(lat), 32'd3);
    chk("hold rdata", 32'(rd), 32'hABCD);
    @(negedge clk);
    chk("hold idle ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("hold no reaccept", 32'(req_ready), 32'd1);
    chk("hold no resp", 32'(resp_valid), 32'd0);

    // Reset landing in ACC1 of a halfword store.
    preload(11'h040, 8'h00);
    preload(11'h041, 8'h77);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_half = 1'b1; req_signed = 1'b0;
    req_addr = 16'h0040; req_wdata = 16'hA55A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= resp_valid;
    @(negedge clk);
    chk("rst ACC1 we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    seen |= resp_valid;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("rst mem lo", 32'(mem[11'h040]), 32'h5A);
    chk("rst mem hi", 32'(mem[11'h041]), 32'h77);
    chk("rst no resp", 32'(seen), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst rdata cleared", 32'(resp_rdata), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
